lsu_mem_initiator: RTL and testbench

- Load/store initiator between the execute stage and the word-addressed data memory.
- Accepts one byte-addressed RV32 load/store per handshake and converts it to word accesses: active-low chip select, write enable, byte mask, lane-aligned store data.
- Captures read data and returns the load result with sign or zero extension.
- Accesses that cross a word boundary are split into two sequential word accesses.

---
 rtl/lsu_mem_initiator_if.sv | 36 +++
 rtl/lsu_mem_initiator.sv | 233 +++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
// Request/response and data-memory signal bundle for the load/store initiator.
// The master modport is the initiator's own view; slave is the requester/memory side.
interface lsu_mem_initiator_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] addrL_LSU;
    logic [ADDR_W-1:0] addrS_LSU;
    logic [31:0]       store;
    logic [3:0]        mask;
    logic              wr_E;
    logic              cs_E;
    logic              Data_Memory_on;
    logic [31:0]       data_rd;

    modport master (
        input  req_valid, is_load, is_store, funct3, addr, wdata, data_rd,
        output req_ready, resp_valid, resp_err, rdata,
        output addrL_LSU, addrS_LSU, store, mask, wr_E, cs_E, Data_Memory_on
    );

    modport slave (
        output req_valid, is_load, is_store, funct3, addr, wdata, data_rd,
        input  req_ready, resp_valid, resp_err, rdata,
        input  addrL_LSU, addrS_LSU, store, mask, wr_E, cs_E, Data_Memory_on
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32 load/store to word-memory initiator with lane alignment and load extension.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two word accesses.
module lsu_mem_initiator #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input logic                 clk_o,
    input logic                 reset,
    lsu_mem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc1 = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
        StAcc2 = 2'd2,
`endif
        StResp = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic        handshake;
    logic [1:0]  in_o;
    logic [29:0] in_w;
    logic [2:0]  in_n;
    logic        in_cross, in_op_ok, in_f3_ok, in_range_ok, in_err;

    logic        is_store_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  o_q;
    logic [31:0] lo_q;
    logic [31:0] shifted, rdata_ext;

    logic              cs_q, cs_d, wr_q, wr_d, on_q, on_d;
    logic [3:0]        mask_q, mask_d;
    logic [31:0]       store_q, store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0] src_wdata;
    logic [1:0]  src_o;
    logic [1:0]  src_size;
    logic [3:0]  nmask;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        cross_q;
    logic [29:0] w_q;
    logic [31:0] wdata_q, hi_q;
    logic [63:0] s_full;
    logic [7:0]  m_full;
`else
    logic [31:0] s_lo;
    logic [3:0]  m_lo;
`endif

    // Request decode, only meaningful while idle
    always_comb begin
        in_o = bus.addr[1:0];
        in_w = bus.addr[31:2];
        case (bus.funct3[1:0])
            2'b00:   in_n = 3'd1;
            2'b01:   in_n = 3'd2;
            default: in_n = 3'd4;
        endcase
        in_cross = (3'(in_o) + in_n) > 3'd4;
        in_op_ok = bus.is_load ^ bus.is_store;
        if (bus.is_store) in_f3_ok = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        else              in_f3_ok = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        in_range_ok = (32'(in_w) < MEM_WORDS) &&
                      (!in_cross || (32'(in_w) + 32'd1 < MEM_WORDS));
`ifdef LSU_MISALIGN_SPLIT_EN
        in_err = !in_op_ok || !in_f3_ok || !in_range_ok;
`else
        in_err = !in_op_ok || !in_f3_ok || !in_range_ok || in_cross;
`endif
    end

    assign handshake = bus.req_valid && (state_q == StIdle);

    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (handshake) state_d = in_err ? StResp : StAcc1;
`ifdef LSU_MISALIGN_SPLIT_EN
            StAcc1: state_d = cross_q ? StAcc2 : StResp;
            StAcc2: state_d = StResp;
`else
            StAcc1: state_d = StResp;
`endif
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_err   = (state_q == StResp) && err_q;
        bus.rdata      = (state_q == StResp && !err_q && !is_store_q) ? rdata_ext : 32'h0;
    end

    // Lane data for the access about to be issued: request inputs in idle, latched otherwise
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        src_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
        src_o     = (state_q == StIdle) ? in_o : o_q;
        src_size  = (state_q == StIdle) ? bus.funct3[1:0] : f3_q[1:0];
`else
        src_wdata = bus.wdata;
        src_o     = in_o;
        src_size  = bus.funct3[1:0];
`endif
        case (src_size)
            2'b00:   nmask = 4'b0001;
            2'b01:   nmask = 4'b0011;
            default: nmask = 4'b1111;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        s_full = {32'h0, src_wdata} << {src_o, 3'b000};
        m_full = {4'h0, nmask} << src_o;
`else
        s_lo = src_wdata << {src_o, 3'b000};
        m_lo = nmask << src_o;
`endif
    end

    always_comb begin
        cs_d    = 1'b1;
        wr_d    = 1'b0;
        on_d    = 1'b0;
        mask_d  = 4'h0;
        store_d = store_q;
        addr_d  = addr_q;
        if (handshake && !in_err) begin
            cs_d   = 1'b0;
            on_d   = 1'b1;
            wr_d   = bus.is_store;
            addr_d = ADDR_W'(in_w);
`ifdef LSU_MISALIGN_SPLIT_EN
            store_d = s_full[31:0];
            mask_d  = bus.is_store ? m_full[3:0] : 4'h0;
`else
            store_d = s_lo;
            mask_d  = bus.is_store ? m_lo : 4'h0;
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        else if (state_q == StAcc1 && cross_q) begin
            cs_d    = 1'b0;
            on_d    = 1'b1;
            wr_d    = is_store_q;
            addr_d  = ADDR_W'(w_q + 30'd1);
            store_d = s_full[63:32];
            mask_d  = is_store_q ? m_full[7:4] : 4'h0;
        end
`endif
    end

    always_ff @(posedge clk_o or negedge reset) begin
        if (!reset) begin
            cs_q       <= 1'b1;
            wr_q       <= 1'b0;
            on_q       <= 1'b0;
            mask_q     <= 4'h0;
            store_q    <= 32'h0;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= 3'b000;
            o_q        <= 2'b00;
            lo_q       <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q    <= 1'b0;
            w_q        <= 30'h0;
            wdata_q    <= 32'h0;
            hi_q       <= 32'h0;
`endif
        end else begin
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            on_q    <= on_d;
            mask_q  <= mask_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            if (handshake) begin
                is_store_q <= bus.is_store;
                err_q      <= in_err;
                f3_q       <= bus.funct3;
                o_q        <= in_o;
`ifdef LSU_MISALIGN_SPLIT_EN
                cross_q    <= in_cross;
                w_q        <= in_w;
                wdata_q    <= bus.wdata;
                hi_q       <= 32'h0;
`endif
            end
            if (state_q == StAcc1 && !is_store_q) lo_q <= bus.data_rd;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == StAcc2 && !is_store_q) hi_q <= bus.data_rd;
`endif
        end
    end

    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        shifted = 32'({hi_q, lo_q} >> {o_q, 3'b000});
`else
        shifted = lo_q >> {o_q, 3'b000};
`endif
        case (f3_q)
            3'b000:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  rdata_ext = shifted;
            3'b100:  rdata_ext = {24'h0, shifted[7:0]};
            3'b101:  rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = 32'h0;
        endcase
    end

    assign bus.cs_E           = cs_q;
    assign bus.wr_E           = wr_q;
    assign bus.Data_Memory_on = on_q;
    assign bus.mask           = mask_q;
    assign bus.store          = store_q;
    assign bus.addrL_LSU      = addr_q;
    assign bus.addrS_LSU      = addr_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: a word memory model, expected-access and
// expected-response queues, and negedge monitors that pop and compare.
module tb_lsu_mem_initiator;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] store;
        logic        chk_store;
    } acc_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
    } rsp_t;

    logic clk_o;
    logic reset;
    logic init_done;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] mem [256];
    acc_t acc_q[$];
    rsp_t rsp_q[$];

    lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

    lsu_mem_initiator #(
        .MEM_WORDS(256),
        .ADDR_W   (32)
    ) dut (
        .clk_o(clk_o),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk_o = 1'b0;
        forever #5 clk_o = ~clk_o;
    end

    always @(posedge clk_o) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: preload while init_done is low, byte-masked write on the falling edge
    always @(negedge clk_o) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[1]   <= 32'h8123FFFF;
            mem[3]   <= 32'h44332211;
            mem[4]   <= 32'h88776655;
            mem[255] <= 32'h12345678;
        end else if (!bus.cs_E && bus.wr_E && bus.addrS_LSU < 32'd256) begin
            for (int b = 0; b < 4; b++)
                if (bus.mask[b]) mem[bus.addrS_LSU[7:0]][8*b +: 8] <= bus.store[8*b +: 8];
        end
    end

    assign bus.data_rd = (bus.addrL_LSU < 32'd256) ? mem[bus.addrL_LSU[7:0]] : 32'h0;

    // Monitor: memory strobes and responses, sampled on the falling edge
    always @(negedge clk_o) begin
        if (init_done) begin
            if (!bus.cs_E) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_strobe", {31'h0, bus.cs_E}, 32'h1);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("acc_wr", {31'h0, bus.wr_E}, {31'h0, a.wr});
                    check("acc_addrL", bus.addrL_LSU, a.addr);
                    check("acc_addrS", bus.addrS_LSU, a.addr);
                    check("acc_mask", {28'h0, bus.mask}, {28'h0, a.mask});
                    check("acc_mem_on", {31'h0, bus.Data_Memory_on}, 32'h1);
                    if (a.chk_store) check("acc_store", bus.store, a.store);
                end
            end else begin
                check("idle_strobes", {26'h0, bus.wr_E, bus.Data_Memory_on, bus.mask},
                      32'h0);
            end
            if (bus.resp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_resp", {31'h0, bus.resp_valid}, 32'h0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("resp_err", {31'h0, bus.resp_err}, {31'h0, r.err});
                    check("resp_rdata", bus.rdata, r.rdata);
                    check("resp_latency", cyc - r.acc_cyc, r.lat);
                    check("resp_ready_low", {31'h0, bus.req_ready}, 32'h0);
                end
            end
        end
    end

    task automatic exp_acc(input logic wr, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] s, input logic cs);
        acc_t e;
        e.wr = wr; e.addr = a; e.mask = m; e.store = s; e.chk_store = cs;
        acc_q.push_back(e);
    endtask

    // Present a request from a falling edge and hold it until accepted
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic err,
                         input logic [31:0] rd, input int lat, output int waits);
        rsp_t e;
        @(negedge clk_o);
        bus.is_load = ld; bus.is_store = st; bus.funct3 = f3;
        bus.addr = a; bus.wdata = wd; bus.req_valid = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < 20) begin
            @(negedge clk_o);
            waits++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        e.err = err; e.rdata = rd; e.lat = lat; e.acc_cyc = cyc;
        rsp_q.push_back(e);
        @(posedge clk_o);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
        check({tag, "_resp"}, {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
        check({tag, "_rdata"}, bus.rdata, 32'h0);
        check({tag, "_cs_E"}, {31'h0, bus.cs_E}, 32'h1);
        check({tag, "_wr_on_mask"}, {26'h0, bus.wr_E, bus.Data_Memory_on, bus.mask}, 32'h0);
        check({tag, "_store"}, bus.store, 32'h0);
        check({tag, "_addrL"}, bus.addrL_LSU, 32'h0);
        check({tag, "_addrS"}, bus.addrS_LSU, 32'h0);
    endtask

    initial begin
        int w;
        int guard;
        reset = 1'b0;
        init_done = 1'b0;
        bus.req_valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
        bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (3) @(negedge clk_o);
        #1 check_reset_vals("in_reset");
        reset = 1'b1;
        init_done = 1'b1;
        @(negedge clk_o);
        #1 check_reset_vals("after_reset");

        // Reset during the ACC1 cycle of SW 0xDEADBEEF @0x10
        @(negedge clk_o);
        bus.is_load = 1'b0; bus.is_store = 1'b1; bus.funct3 = 3'b010;
        bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
        @(posedge clk_o);
        #1 check("pre_reset_cs_E", {31'h0, bus.cs_E}, 32'h0);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        #1 check("mid_reset_cs_E", {31'h0, bus.cs_E}, 32'h1);
        @(negedge clk_o);
        #1 check("mem4_unchanged", mem[4], 32'h88776655);
        reset = 1'b1;
        @(negedge clk_o);
        #1 check_reset_vals("post_mid_reset");

        // LH / LHU @0x06, word1 = 0x8123FFFF
        exp_acc(1'b0, 32'd1, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h06, 32'h0, 1'b0, 32'hFFFF8123, 2, w);
        exp_acc(1'b0, 32'd1, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b101, 32'h06, 32'h0, 1'b0, 32'h00008123, 2, w);

        // Split LW @0x0D: bytes 0x0D..0x10 = 22 33 44 55
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_acc(1'b0, 32'd3, 4'h0, 32'h0, 1'b0);
        exp_acc(1'b0, 32'd4, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h0D, 32'h0, 1'b0, 32'h55443322, 3, w);
`else
        issue(1'b1, 1'b0, 3'b010, 32'h0D, 32'h0, 1'b1, 32'h0, 1, w);
`endif

        // SB 0xA5 @0x0E -> word3 = 0x44A52211
        exp_acc(1'b1, 32'd3, 4'b0100, 32'h00A50000, 1'b1);
        issue(1'b0, 1'b1, 3'b000, 32'h0E, 32'h000000A5, 1'b0, 32'h0, 2, w);

        // Split SW 0xAABBCCDD @0x0B
`ifdef LSU_MISALIGN_SPLIT_EN
        exp_acc(1'b1, 32'd2, 4'b1000, 32'hDD000000, 1'b1);
        exp_acc(1'b1, 32'd3, 4'b0111, 32'h00AABBCC, 1'b1);
        issue(1'b0, 1'b1, 3'b010, 32'h0B, 32'hAABBCCDD, 1'b0, 32'h0, 3, w);
        exp_acc(1'b0, 32'd3, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 32'h44AABBCC, 2, w);
        exp_acc(1'b0, 32'd2, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDD000000, 2, w);
        exp_acc(1'b0, 32'd3, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b000, 32'h0E, 32'h0, 1'b0, 32'hFFFFFFAA, 2, w);
`else
        issue(1'b0, 1'b1, 3'b010, 32'h0B, 32'hAABBCCDD, 1'b1, 32'h0, 1, w);
        exp_acc(1'b0, 32'd3, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 32'h44A52211, 2, w);
        exp_acc(1'b0, 32'd2, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'h00000000, 2, w);
        exp_acc(1'b0, 32'd3, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b000, 32'h0E, 32'h0, 1'b0, 32'hFFFFFFA5, 2, w);
`endif

        // Error cases: no strobe, response on the cycle after accept
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 1, w);
        issue(1'b1, 1'b0, 3'b010, 32'h3FD, 32'h0, 1'b1, 32'h0, 1, w);
        issue(1'b1, 1'b0, 3'b011, 32'h04, 32'h0, 1'b1, 32'h0, 1, w);
        issue(1'b0, 1'b1, 3'b100, 32'h04, 32'h55, 1'b1, 32'h0, 1, w);
        issue(1'b1, 1'b1, 3'b010, 32'h04, 32'h0, 1'b1, 32'h0, 1, w);
        issue(1'b0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b1, 32'h0, 1, w);

        // Back-to-back aligned loads; the second waits out ACC1 and RESP
        exp_acc(1'b0, 32'd1, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'h8123FFFF, 2, w);
        exp_acc(1'b0, 32'd255, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'h12345678, 2, w);
        check("b2b_wait_cycles", w, 2);

        // Non-crossing unaligned SH @0x05 then read back word1
        exp_acc(1'b1, 32'd1, 4'b0110, 32'h00123400, 1'b1);
        issue(1'b0, 1'b1, 3'b001, 32'h05, 32'h00001234, 1'b0, 32'h0, 2, w);
        exp_acc(1'b0, 32'd1, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'h811234FF, 2, w);

        guard = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0) && guard < 50) begin
            @(negedge clk_o);
            guard++;
        end
        repeat (3) @(negedge clk_o);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("acc_queue_drained", acc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
